lmem_hd_unload_streamer: RTL and testbench

- Drains hard decisions from the Lmem unload port after decoding finishes.
- Walks unload addresses 0..UNLOAD_DEPTH-1 and captures each KB*HDWIDTH-bit hard-decision vector.
- Re-serialises each vector into OUTW-bit words on a valid/ready stream toward the host/output interface.
- Replaces bench-driven single-address unload with a parametrised, back-pressure-aware sequencer.

---
 rtl/lmem_hd_unload_streamer.sv | 211 +++++++++++++++++++++
 tb/tb_lmem_hd_unload_streamer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lmem_hd_unload_streamer.sv
// Drains Lmem hard decisions after decoding and re-serialises each KB*HDWIDTH-bit
// unload vector into OUTW-bit valid/ready words. Optional: LMEM_HD_UNLOAD_PREFETCH_EN.
module lmem_hd_unload_streamer #(
    parameter int KB           = 14,
    parameter int HDWIDTH      = 32,
    parameter int UNLOAD_DEPTH = 17,
    parameter int ADDRESSWIDTH = 5,
    parameter int RD_LATENCY   = 2,
    parameter int OUTW         = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    unload_en,
    output logic [ADDRESSWIDTH-1:0] unloadAddress,
    input  logic [KB*HDWIDTH-1:0]   hd_in,
    output logic [OUTW-1:0]         out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);

    localparam int VW    = KB * HDWIDTH;
    localparam int WORDS = VW / OUTW;
    localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [ADDRESSWIDTH-1:0] LAST_ADDR = ADDRESSWIDTH'(UNLOAD_DEPTH - 1);
    localparam logic [WW-1:0]           LAST_WORD = WW'(WORDS - 1);
    localparam logic [2:0]              LAT_LAST  = 3'(RD_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, STREAM, DONE} state_t;

    state_t                  state_q;
    logic [ADDRESSWIDTH-1:0] addr_q;
    logic [ADDRESSWIDTH-1:0] uaddr_q;
    logic [WW-1:0]           word_q;
    logic [2:0]              lat_q;
    logic                    pend_q;
    logic                    unload_en_q;
    logic [OUTW-1:0]         out_data_q;
    logic                    out_valid_q;
    logic                    out_last_q;
    logic                    busy_q;
    logic                    done_q;
`ifdef LMEM_HD_UNLOAD_PREFETCH_EN
    logic [VW-1:0]           buf_q [2];
    logic                    rd_sel_q;
    logic                    wr_sel_q;
    logic                    avail_q;
`else
    logic [VW-1:0]           line_q;
`endif

    logic                    fill;
    logic                    xfer;
    logic                    line_end;
    logic                    line_rdy;
    logic                    launch;
    logic [ADDRESSWIDTH-1:0] launch_addr;
    logic [OUTW-1:0]         launch_word;
    logic [VW-1:0]           cur_line;
    logic [WW-1:0]           nxt_word;

    // One read is ever outstanding; fill marks the edge its data is captured.
    assign fill     = pend_q && (lat_q == LAT_LAST);
    assign xfer     = out_valid_q && out_ready;
    assign line_end = xfer && (word_q == LAST_WORD);
    assign nxt_word = word_q + 1'b1;

`ifdef LMEM_HD_UNLOAD_PREFETCH_EN
    assign line_rdy = fill || avail_q;
    assign cur_line = buf_q[rd_sel_q];
`else
    assign line_rdy = fill;
    assign cur_line = line_q;
`endif

    always_comb begin
        launch      = 1'b0;
        launch_addr = addr_q;
        launch_word = hd_in[OUTW-1:0];
`ifdef LMEM_HD_UNLOAD_PREFETCH_EN
        // rd_sel_q flips at line end, so a switch in STREAM reads the other buffer
        if (!fill)
            launch_word = (state_q == STREAM) ? buf_q[~rd_sel_q][OUTW-1:0]
                                              : buf_q[rd_sel_q][OUTW-1:0];
        if (state_q == STREAM && line_end && addr_q != LAST_ADDR) begin
            launch      = line_rdy;
            launch_addr = addr_q + 1'b1;
        end
`endif
        if (state_q == WAIT)
            launch = line_rdy;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            uaddr_q     <= '0;
            word_q      <= '0;
            lat_q       <= '0;
            pend_q      <= 1'b0;
            unload_en_q <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef LMEM_HD_UNLOAD_PREFETCH_EN
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
            rd_sel_q    <= 1'b0;
            wr_sel_q    <= 1'b0;
            avail_q     <= 1'b0;
`else
            line_q      <= '0;
`endif
        end else begin
            if (unload_en_q) begin
                unload_en_q <= 1'b0;
                pend_q      <= 1'b1;
                lat_q       <= '0;
            end else if (pend_q) begin
                lat_q <= lat_q + 3'd1;
                if (fill) begin
                    pend_q <= 1'b0;
`ifdef LMEM_HD_UNLOAD_PREFETCH_EN
                    buf_q[wr_sel_q] <= hd_in;
                    wr_sel_q        <= ~wr_sel_q;
                    avail_q         <= 1'b1;
`else
                    line_q <= hd_in;
`endif
                end
            end

            case (state_q)
                IDLE: if (start) begin
                    state_q     <= ISSUE;
                    addr_q      <= '0;
                    uaddr_q     <= '0;
                    unload_en_q <= 1'b1;
                    busy_q      <= 1'b1;
`ifdef LMEM_HD_UNLOAD_PREFETCH_EN
                    rd_sel_q    <= 1'b0;
                    wr_sel_q    <= 1'b0;
                    avail_q     <= 1'b0;
`endif
                end
                ISSUE: state_q <= WAIT;
                WAIT: if (launch) state_q <= STREAM;
                STREAM: if (xfer) begin
                    if (word_q == LAST_WORD) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (addr_q == LAST_ADDR) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            addr_q <= addr_q + 1'b1;
`ifdef LMEM_HD_UNLOAD_PREFETCH_EN
                            rd_sel_q <= ~rd_sel_q;
                            if (!launch) state_q <= WAIT;
`else
                            uaddr_q     <= addr_q + 1'b1;
                            unload_en_q <= 1'b1;
                            state_q     <= ISSUE;
`endif
                        end
                    end else begin
                        word_q     <= nxt_word;
                        out_data_q <= cur_line[32'(nxt_word)*OUTW +: OUTW];
                        out_last_q <= (addr_q == LAST_ADDR) && (nxt_word == LAST_WORD);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // Line start overrides the end-of-line deassertion so lines run back to back
            if (launch) begin
                word_q      <= '0;
                out_valid_q <= 1'b1;
                out_data_q  <= launch_word;
                out_last_q  <= (launch_addr == LAST_ADDR) && (WORDS == 1);
`ifdef LMEM_HD_UNLOAD_PREFETCH_EN
                avail_q <= 1'b0;
                if (launch_addr != LAST_ADDR) begin
                    unload_en_q <= 1'b1;
                    uaddr_q     <= launch_addr + 1'b1;
                end
`endif
            end
        end
    end

    assign unload_en     = unload_en_q;
    assign unloadAddress = uaddr_q;
    assign out_data      = out_data_q;
    assign out_valid     = out_valid_q;
    assign out_last      = out_last_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_lmem_hd_unload_streamer.sv
// Directed bench for lmem_hd_unload_streamer: default instance plus a small
// UNLOAD_DEPTH=4 / OUTW=64 / RD_LATENCY=3 instance, each with a simple Lmem model.
module tb_lmem_hd_unload_streamer;

`ifdef LMEM_HD_UNLOAD_PREFETCH_EN
    localparam int DRAIN    = 1 + 2 + 17*14 + 1;
    localparam int DRAIN2   = 1 + 3 + 4*7 + 1;
    localparam int FIRSTGAP = 3;
    localparam int SPACING  = 14;
`else
    localparam int DRAIN    = 17*(1 + 2 + 14) + 1;
    localparam int DRAIN2   = 4*(1 + 3 + 7) + 1;
    localparam int FIRSTGAP = 17;
    localparam int SPACING  = 17;
`endif

    logic clk = 1'b0;
    logic rst, start, start2, out_ready, out_ready2;
    logic unload_en, unload_en2, out_valid, out_valid2, out_last, out_last2;
    logic busy, busy2, done, done2;
    logic [4:0] unloadAddress, unloadAddress2;
    logic [447:0] hd_in, hd_in2;
    logic [31:0] out_data;
    logic [63:0] out_data2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lmem_hd_unload_streamer dut (
        .clk(clk), .rst(rst), .start(start), .unload_en(unload_en),
        .unloadAddress(unloadAddress), .hd_in(hd_in), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .done(done)
    );

    lmem_hd_unload_streamer #(.UNLOAD_DEPTH(4), .OUTW(64), .RD_LATENCY(3)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .unload_en(unload_en2),
        .unloadAddress(unloadAddress2), .hd_in(hd_in2), .out_data(out_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_last(out_last2),
        .busy(busy2), .done(done2)
    );

    function automatic logic [31:0] exp_col(input logic [4:0] a, input int c);
        return {a, 27'h5A5A5A5 ^ 27'(c)};
    endfunction

    function automatic logic [447:0] hd_vec(input logic [4:0] a);
        logic [447:0] v;
        for (int c = 0; c < 14; c++) v[c*32 +: 32] = exp_col(a, c);
        return v;
    endfunction

    function automatic logic [31:0] exp32(input int i);
        return exp_col(5'(i / 14), i % 14);
    endfunction

    function automatic logic [63:0] exp64(input int i);
        return {exp_col(5'(i / 7), 2*(i % 7) + 1), exp_col(5'(i / 7), 2*(i % 7))};
    endfunction

    // Lmem models: registered input, registered output that holds its last read
    logic       pv = 1'b0;
    logic [4:0] pa = '0, hold = '0;
    logic [1:0] pv2 = '0;
    logic [4:0] pa2 [2];
    logic [4:0] hold2 = '0;
    always @(posedge clk) begin
        pv <= unload_en; pa <= unloadAddress;
        if (pv) hold <= pa;
        pv2 <= {pv2[0], unload_en2}; pa2[0] <= unloadAddress2; pa2[1] <= pa2[0];
        if (pv2[1]) hold2 <= pa2[1];
    end
    assign hd_in  = hd_vec(hold);
    assign hd_in2 = hd_vec(hold2);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Monitor (negedge sampling)
    logic [31:0] q_data [$];
    logic        q_last [$];
    logic [4:0]  q_ua [$];
    int          q_uat [$];
    logic [63:0] q2_data [$];
    logic        q2_last [$];
    logic [4:0]  q2_ua [$];
    int ncyc = 0, vcnt = 0, vfirst = 0, vlast = 0, done_cnt = 0, done2_cnt = 0;
    logic        stall_q = 1'b0;
    logic [31:0] stall_data = '0;

    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q && out_valid) check("stall_hold", out_data, stall_data);
            stall_q    = out_valid && !out_ready;
            stall_data = out_data;
            if (out_valid && out_ready) begin
                q_data.push_back(out_data); q_last.push_back(out_last);
            end
            if (out_valid) begin
                if (vcnt == 0) vfirst = ncyc;
                vlast = ncyc; vcnt++;
            end
            if (done) done_cnt++;
            if (unload_en) begin q_ua.push_back(unloadAddress); q_uat.push_back(ncyc); end
            if (out_valid2 && out_ready2) begin
                q2_data.push_back(out_data2); q2_last.push_back(out_last2);
            end
            if (done2) done2_cnt++;
            if (unload_en2) q2_ua.push_back(unloadAddress2);
        end
    end

    task automatic clear_mon();
        q_data.delete(); q_last.delete(); q_ua.delete(); q_uat.delete();
        q2_data.delete(); q2_last.delete(); q2_ua.delete();
        vcnt = 0; done_cnt = 0; done2_cnt = 0;
    endtask

    task automatic check_stream(input string tag);
        int nl;
        check({tag, "_count"}, 64'(q_data.size()), 64'd238);
        for (int i = 0; i < 238; i++) check({tag, "_word"}, q_data[i], exp32(i));
        nl = 0;
        foreach (q_last[i]) if (q_last[i]) nl++;
        check({tag, "_last_count"}, 64'(nl), 64'd1);
        check({tag, "_last_pos"}, 64'(q_last[237]), 64'd1);
    endtask

    initial begin
        int n, nl;
        logic [3:0] pat;
        pat = 4'b1001;
        rst = 1'b1; start = 1'b0; start2 = 1'b0; out_ready = 1'b1; out_ready2 = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_unload_en", unload_en, 0);
        check("rst_addr", unloadAddress, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full drain with out_ready held high
        clear_mon();
        start = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; start = 1'b0; end while (!done && n < 3000);
        check("drain_cycles", 64'(n), 64'(DRAIN));
        check("busy_in_done", busy, 1);
        repeat (3) @(negedge clk);
        check_stream("t1");
        check("t1_first_literal", q_data[0], 64'h05A5A5A5);
        check("t1_final_literal", q_data[237], 64'h85A5A5A8);
        check("t1_done_count", 64'(done_cnt), 64'd1);
        check("t1_busy_after", busy, 0);
        check("t1_valid_after", out_valid, 0);
        check("t1_issue_count", 64'(q_ua.size()), 64'd17);
        for (int i = 0; i < 17; i++) check("t1_issue_addr", q_ua[i], 64'(i));
        check("t1_first_gap", 64'(q_uat[1] - q_uat[0]), 64'(FIRSTGAP));
        for (int i = 2; i < 17; i++) check("t1_issue_gap", 64'(q_uat[i] - q_uat[i-1]), 64'(SPACING));
`ifdef LMEM_HD_UNLOAD_PREFETCH_EN
        check("t1_valid_cycles", 64'(vcnt), 64'd238);
        check("t1_valid_span", 64'(vlast - vfirst + 1), 64'd238);
`endif

        // Back-pressure pattern 1,0,0,1
        clear_mon();
        start = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            out_ready = pat[n % 4];
            n++;
        end while (!done && n < 4000);
        check("t2_done_seen", done, 1);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_stream("t2");
        check("t2_done_count", 64'(done_cnt), 64'd1);

        // Asynchronous reset at addr 9 word 5
        clear_mon();
        start = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; start = 1'b0; n++; end while (q_data.size() < 131 && n < 3000);
        check("t3_pre_reset_word", out_data, exp32(131));
        check("t3_pre_reset_valid", out_valid, 1);
        #1 rst = 1'b1;
        #1;
        check("t3_rst_unload_en", unload_en, 0);
        check("t3_rst_addr", unloadAddress, 0);
        check("t3_rst_out_data", out_data, 0);
        check("t3_rst_out_valid", out_valid, 0);
        check("t3_rst_out_last", out_last, 0);
        check("t3_rst_busy", busy, 0);
        check("t3_rst_done", done, 0);
        repeat (3) @(negedge clk);
        clear_mon();
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("t3_idle_valid", out_valid, 0);
        check("t3_idle_unload_en", unload_en, 0);
        check("t3_idle_busy", busy, 0);
        check("t3_no_partial", 64'(q_data.size()), 64'd0);
        start = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; start = 1'b0; end while (!done && n < 3000);
        check("t3_drain_cycles", 64'(n), 64'(DRAIN));
        repeat (3) @(negedge clk);
        check_stream("t3");

        // Second start while busy is ignored
        clear_mon();
        start = 1'b1;
        n = 0;
        do begin
            @(negedge clk); n++;
            start = (n == 40);
            if (n == 20) check("t4_busy_mid", busy, 1);
        end while (!done && n < 3000);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check_stream("t4");
        check("t4_done_count", 64'(done_cnt), 64'd1);
        check("t4_busy_after", busy, 0);
        check("t4_issue_count", 64'(q_ua.size()), 64'd17);

        // Small configuration: 4 addresses, 64-bit words, latency 3
        clear_mon();
        start2 = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; start2 = 1'b0; end while (!done2 && n < 1000);
        check("t5_drain_cycles", 64'(n), 64'(DRAIN2));
        repeat (3) @(negedge clk);
        check("t5_count", 64'(q2_data.size()), 64'd28);
        for (int i = 0; i < 28; i++) check("t5_word", q2_data[i], exp64(i));
        check("t5_final_literal", q2_data[27], 64'h1DA5A5A8_1DA5A5A9);
        nl = 0;
        foreach (q2_last[i]) if (q2_last[i]) nl++;
        check("t5_last_count", 64'(nl), 64'd1);
        check("t5_last_pos", 64'(q2_last[27]), 64'd1);
        check("t5_issue_count", 64'(q2_ua.size()), 64'd4);
        for (int i = 0; i < 4; i++) check("t5_issue_addr", q2_ua[i], 64'(i));
        check("t5_done_count", 64'(done2_cnt), 64'd1);
        check("t5_busy_after", busy2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
